// File: rtl/spare_alloc_search_if.sv
// Handshake and CAM snapshot bundle for the spare-allocation search engine.
// The master drives start/abort and CAM contents; the slave returns results.
interface spare_alloc_search_if #(
  parameter int PCAM  = 8,
  parameter int NPCAM = 30,
  parameter int ROW_W = 10,
  parameter int COL_W = 10
);
  localparam int UC_W = $clog2(NPCAM + 1);

  logic                     start;
  logic                     abort;
  logic [PCAM-1:0]          pivot_valid;
  logic [PCAM*ROW_W-1:0]    pivot_row;
  logic [PCAM*COL_W-1:0]    pivot_col;
  logic [NPCAM-1:0]         np_valid;
  logic [NPCAM*ROW_W-1:0]   np_row;
  logic [NPCAM*COL_W-1:0]   np_col;
  logic                     busy;
  logic                     done;
  logic                     success;
  logic                     best_valid;
  logic [PCAM-1:0]          repair_sel;
  logic [UC_W-1:0]          uncover_cnt;

  modport master (
    output start, abort,
    output pivot_valid, pivot_row, pivot_col,
    output np_valid, np_row, np_col,
    input  busy, done, success, best_valid,
    input  repair_sel, uncover_cnt
  );

  modport slave (
    input  start, abort,
    input  pivot_valid, pivot_row, pivot_col,
    input  np_valid, np_row, np_col,
    output busy, done, success, best_valid,
    output repair_sel, uncover_cnt
  );
endinterface

// File: rtl/spare_alloc_search.sv
// Exhaustive row/column spare assignment search over pivot faults,
// one candidate per cycle, keeping the legal candidate with fewest misses.
module spare_alloc_search #(
  parameter int PCAM   = 8,
  parameter int NPCAM  = 30,
  parameter int ROW_W  = 10,
  parameter int COL_W  = 10,
  parameter int NUM_SR = 4,
  parameter int NUM_SC = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  spare_alloc_search_if.slave bus
);

  localparam int UC_W = $clog2(NPCAM + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEARCH, S_DRAIN, S_DONE
  } state_t;

  state_t                 state_q;
  logic                   busy_q, done_q;
  logic                   succ_q, bv_q;
  logic [PCAM-1:0]        sel_q;
  logic [UC_W-1:0]        unc_q;

  logic [PCAM-1:0]        pv_q;
  logic [PCAM*ROW_W-1:0]  pr_q;
  logic [PCAM*COL_W-1:0]  pc_q;
  logic [NPCAM-1:0]       nv_q;
  logic [NPCAM*ROW_W-1:0] nr_q;
  logic [NPCAM*COL_W-1:0] nc_q;
  logic [PCAM-1:0]        cand_q;

  logic                   ev_vld_q, ev_legal_q;
  logic [UC_W-1:0]        ev_unc_q;
  logic [PCAM-1:0]        ev_sel_q;

  int                     n_piv, n_row, n_col, n_unc;
  logic                   cov;
  logic                   legal_d;
  logic [UC_W-1:0]        unc_d;
  logic                   upd, hit;

  always_comb begin
    n_piv = 0;
    n_row = 0;
    n_col = 0;
    n_unc = 0;
    cov   = 1'b0;
    for (int i = 0; i < PCAM; i++) begin
      if (pv_q[i]) begin
        n_piv = n_piv + 1;
        if (cand_q[i]) n_row = n_row + 1;
        else           n_col = n_col + 1;
      end
    end
    for (int j = 0; j < NPCAM; j++) begin
      cov = !nv_q[j];
      for (int i = 0; i < PCAM; i++) begin
        if (pv_q[i] && cand_q[i] &&
            pr_q[i*ROW_W +: ROW_W] == nr_q[j*ROW_W +: ROW_W])
          cov = 1'b1;
        if (pv_q[i] && !cand_q[i] &&
            pc_q[i*COL_W +: COL_W] == nc_q[j*COL_W +: COL_W])
          cov = 1'b1;
      end
      if (!cov) n_unc = n_unc + 1;
    end
    legal_d = ((cand_q & ~pv_q) == '0) &&
              (n_row <= NUM_SR) && (n_col <= NUM_SC);
    unc_d   = UC_W'(n_unc);
  end

  // Strict less-than keeps the lowest-numbered candidate on ties.
  assign upd = ev_vld_q && ev_legal_q &&
               (!bv_q || ev_unc_q < unc_q);
  assign hit = ev_vld_q && ev_legal_q && ev_unc_q == '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      succ_q     <= 1'b0;
      bv_q       <= 1'b0;
      sel_q      <= '0;
      unc_q      <= '0;
      pv_q       <= '0;
      pr_q       <= '0;
      pc_q       <= '0;
      nv_q       <= '0;
      nr_q       <= '0;
      nc_q       <= '0;
      cand_q     <= '0;
      ev_vld_q   <= 1'b0;
      ev_legal_q <= 1'b0;
      ev_unc_q   <= '0;
      ev_sel_q   <= '0;
    end else if (bus.abort) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ev_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            pv_q     <= bus.pivot_valid;
            pr_q     <= bus.pivot_row;
            pc_q     <= bus.pivot_col;
            nv_q     <= bus.np_valid;
            nr_q     <= bus.np_row;
            nc_q     <= bus.np_col;
            succ_q   <= 1'b0;
            bv_q     <= 1'b0;
            sel_q    <= '0;
            unc_q    <= UC_W'(NPCAM);
            ev_vld_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          cand_q <= '0;
          if (n_piv > NUM_SR + NUM_SC) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (upd) begin
            bv_q  <= 1'b1;
            sel_q <= ev_sel_q;
            unc_q <= ev_unc_q;
          end
          if (hit) begin
            succ_q   <= 1'b1;
            ev_vld_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            ev_vld_q   <= 1'b1;
            ev_legal_q <= legal_d;
            ev_unc_q   <= unc_d;
            ev_sel_q   <= cand_q;
            cand_q     <= cand_q + PCAM'(1);
            if (cand_q == '1) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (upd) begin
            bv_q  <= 1'b1;
            sel_q <= ev_sel_q;
            unc_q <= ev_unc_q;
          end
          if (hit) succ_q <= 1'b1;
          ev_vld_q <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.success     = succ_q;
  assign bus.best_valid  = bv_q;
  assign bus.repair_sel  = sel_q;
  assign bus.uncover_cnt = unc_q;

endmodule

// File: tb/tb_spare_alloc_search.sv
// Bench for spare_alloc_search: directed scenarios plus random CAM contents
// against a brute-force reference search, on 4+4 and 2+2 spare instances.
module tb_spare_alloc_search;

  localparam int PCAM  = 8;
  localparam int NPCAM = 30;
  localparam int ROW_W = 10;
  localparam int COL_W = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic start, abort;
  logic [PCAM-1:0]        pv;
  logic [PCAM*ROW_W-1:0]  prow;
  logic [PCAM*COL_W-1:0]  pcol;
  logic [NPCAM-1:0]       npv;
  logic [NPCAM*ROW_W-1:0] nrow;
  logic [NPCAM*COL_W-1:0] ncol;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spare_alloc_search_if #(.PCAM(PCAM), .NPCAM(NPCAM),
    .ROW_W(ROW_W), .COL_W(COL_W)) ia ();
  spare_alloc_search_if #(.PCAM(PCAM), .NPCAM(NPCAM),
    .ROW_W(ROW_W), .COL_W(COL_W)) ib ();

  assign ia.start = start;
  assign ia.abort = abort;
  assign ia.pivot_valid = pv;
  assign ia.pivot_row = prow;
  assign ia.pivot_col = pcol;
  assign ia.np_valid = npv;
  assign ia.np_row = nrow;
  assign ia.np_col = ncol;
  assign ib.start = start;
  assign ib.abort = abort;
  assign ib.pivot_valid = pv;
  assign ib.pivot_row = prow;
  assign ib.pivot_col = pcol;
  assign ib.np_valid = npv;
  assign ib.np_row = nrow;
  assign ib.np_col = ncol;

  spare_alloc_search #(.PCAM(PCAM), .NPCAM(NPCAM), .ROW_W(ROW_W),
    .COL_W(COL_W), .NUM_SR(4), .NUM_SC(4))
    u_a (.clk(clk), .rst_n(rst_n), .bus(ia));

  spare_alloc_search #(.PCAM(PCAM), .NPCAM(NPCAM), .ROW_W(ROW_W),
    .COL_W(COL_W), .NUM_SR(2), .NUM_SC(2))
    u_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_cams();
    pv = '0; prow = '0; pcol = '0;
    npv = '0; nrow = '0; ncol = '0;
  endtask

  task automatic set_piv(input int i, input int r, input int c);
    pv[i] = 1'b1;
    prow[i*ROW_W +: ROW_W] = ROW_W'(r);
    pcol[i*COL_W +: COL_W] = COL_W'(c);
  endtask

  task automatic set_np(input int j, input int r, input int c);
    npv[j] = 1'b1;
    nrow[j*ROW_W +: ROW_W] = ROW_W'(r);
    ncol[j*COL_W +: COL_W] = COL_W'(c);
  endtask

  task automatic scen2();
    clear_cams();
    set_piv(0, 5, 7);
    set_piv(1, 9, 3);
    set_np(0, 5, 20);
  endtask

  task automatic scen4();
    clear_cams();
    set_piv(0, 1, 1);
    set_np(0, 1, 2);
    set_np(1, 2, 1);
  endtask

  task automatic rand_cams();
    clear_cams();
    for (int i = 0; i < PCAM; i++)
      if ($urandom_range(0, 1) == 1)
        set_piv(i, $urandom_range(0, 3), $urandom_range(0, 3));
    for (int j = 0; j < NPCAM; j++)
      if ($urandom_range(0, 3) == 0)
        set_np(j, $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  // Brute force over all assignments: a pivot on a row spare repairs
  // its row, otherwise its column; spare budgets bound each kind.
  function automatic void model(input int nsr, input int nsc,
    output int e_done, output logic e_succ, output logic e_bv,
    output logic [PCAM-1:0] e_sel, output int e_unc);
    int nv, nr, unc;
    logic [PCAM-1:0] sel;
    logic hitj;
    nv = $countones(pv);
    e_succ = 1'b0; e_bv = 1'b0; e_sel = '0; e_unc = NPCAM;
    if (nv > nsr + nsc) begin
      e_done = 2;
      return;
    end
    e_done = 3 + (1 << PCAM);
    for (int k = 0; k < (1 << PCAM); k++) begin
      sel = PCAM'(k);
      if ((sel & ~pv) != '0) continue;
      nr = $countones(sel & pv);
      if (nr > nsr || nv - nr > nsc) continue;
      unc = 0;
      for (int j = 0; j < NPCAM; j++) begin
        if (!npv[j]) continue;
        hitj = 1'b0;
        for (int i = 0; i < PCAM; i++) begin
          if (!pv[i]) continue;
          if (sel[i] && prow[i*ROW_W +: ROW_W] == nrow[j*ROW_W +: ROW_W])
            hitj = 1'b1;
          if (!sel[i] && pcol[i*COL_W +: COL_W] == ncol[j*COL_W +: COL_W])
            hitj = 1'b1;
        end
        if (!hitj) unc++;
      end
      if (!e_bv || unc < e_unc) begin
        e_bv = 1'b1; e_unc = unc; e_sel = sel;
      end
      if (unc == 0) begin
        e_succ = 1'b1;
        e_done = 4 + k;
        return;
      end
    end
  endfunction

  // Called at a negedge in cycle 0; start is sampled at the next posedge.
  task automatic run(input string nm, input int abort_cyc,
                     input int rst_cyc, input int ign_cyc,
                     input bit expect_done);
    int ea_d, eb_d, ea_u, eb_u, da, db;
    logic ea_s, ea_b, eb_s, eb_b, busy_ok;
    logic [PCAM-1:0] ea_sel, eb_sel;
    logic ra_s, ra_b, rb_s, rb_b;
    logic [PCAM-1:0] ra_sel, rb_sel;
    logic [7:0] ra_u, rb_u;
    model(4, 4, ea_d, ea_s, ea_b, ea_sel, ea_u);
    model(2, 2, eb_d, eb_s, eb_b, eb_sel, eb_u);
    da = -1; db = -1; busy_ok = 1'b1;
    ra_s = 0; ra_b = 0; ra_sel = 0; ra_u = 0;
    rb_s = 0; rb_b = 0; rb_sel = 0; rb_u = 0;
    start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (c == ign_cyc) begin
        scen2();
        start = 1'b1;
      end
      if (c == abort_cyc) abort = 1'b1;
      if (abort_cyc > 0 && c == abort_cyc + 1)
        chk({nm, "_abort_busy"}, ia.busy, 0);
      if (c == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        chk({nm, "_rst_out"}, {ia.busy, ia.done, ia.success,
          ia.best_valid, ia.repair_sel, ia.uncover_cnt}, 0);
      end
      if (rst_cyc > 0 && c == rst_cyc + 3) rst_n = 1'b1;
      if (expect_done && c == ea_d - 1)
        chk({nm, "_pre_done"}, {ia.busy, ia.done}, 2'b10);
      if (da >= 0 && c == da + 1)
        chk({nm, "_busy_after"}, {ia.busy, ia.done}, 2'b00);
      if (da < 0 && ia.done) begin
        da = c; ra_s = ia.success; ra_b = ia.best_valid;
        ra_sel = ia.repair_sel; ra_u = 8'(ia.uncover_cnt);
      end
      if (db < 0 && ib.done) begin
        db = c; rb_s = ib.success; rb_b = ib.best_valid;
        rb_sel = ib.repair_sel; rb_u = 8'(ib.uncover_cnt);
      end
      if (expect_done && da < 0 && !ia.busy) busy_ok = 1'b0;
      if (da >= 0 && db >= 0 && c > da + 1 && c > db + 1) break;
    end
    if (expect_done) begin
      chk({nm, "_a_done_cyc"}, da, ea_d);
      chk({nm, "_a_success"}, ra_s, ea_s);
      chk({nm, "_a_best_valid"}, ra_b, ea_b);
      chk({nm, "_a_sel"}, ra_sel, ea_sel);
      chk({nm, "_a_unc"}, ra_u, ea_u);
      chk({nm, "_a_busy_run"}, busy_ok, 1'b1);
      chk({nm, "_b_done_cyc"}, db, eb_d);
      chk({nm, "_b_success"}, rb_s, eb_s);
      chk({nm, "_b_best_valid"}, rb_b, eb_b);
      chk({nm, "_b_sel"}, rb_sel, eb_sel);
      chk({nm, "_b_unc"}, rb_u, eb_u);
    end else begin
      chk({nm, "_a_no_done"}, da, -1);
      chk({nm, "_b_no_done"}, db, -1);
    end
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    rand_cams();
    repeat (3) @(negedge clk);
    chk("reset_a", {ia.busy, ia.done, ia.success, ia.best_valid,
      ia.repair_sel, ia.uncover_cnt}, 0);
    chk("reset_b", {ib.busy, ib.done, ib.success, ib.best_valid,
      ib.repair_sel, ib.uncover_cnt}, 0);
    rst_n = 1'b1;
    start = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ia.busy || ia.done || ib.busy || ib.done) seen = 1'b1;
    end
    chk("idle_no_start", seen, 1'b0);

    scen2();
    run("scen2", -1, -1, -1, 1'b1);
    chk("scen2_sel_const", ia.repair_sel, 8'h01);

    clear_cams();
    for (int i = 0; i < 5; i++) set_piv(i, 10 + i, 20 + i);
    set_np(0, 99, 99);
    run("fastfail", -1, -1, -1, 1'b1);
    chk("fastfail_unc_const", ib.uncover_cnt, 30);

    scen4();
    run("scen4_ign", -1, -1, 10, 1'b1);
    chk("scen4_unc_const", ia.uncover_cnt, 1);

    scen4();
    run("abort", 50, -1, -1, 1'b0);
    scen2();
    run("scen2_after_abort", -1, -1, -1, 1'b1);

    scen4();
    run("async_rst", -1, 40, -1, 1'b0);
    scen2();
    run("scen2_after_rst", -1, -1, -1, 1'b1);

    for (int n = 0; n < 12; n++) begin
      rand_cams();
      run($sformatf("rand%0d", n), -1, -1, -1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spare_alloc_search.md
# spare_alloc_search

Sequential, parametrised spare-allocation search engine for the BIRA datapath. It takes a snapshot of the pivot and non-pivot fault CAM contents and enumerates every row/column assignment of the pivot faults, one candidate per cycle. For each candidate it checks spare budgets and non-pivot coverage. It reports the first fully-covering legal assignment, or the best-effort assignment with the fewest uncovered non-pivot faults.

## Interface
Parameters:
- PCAM, 8, pivot CAM entries; also the width of the candidate select vector
- NPCAM, 30, non-pivot CAM entries
- ROW_W, 10, row address width
- COL_W, 10, column address width
- NUM_SR, 4, spare rows available
- NUM_SC, 4, spare columns available

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; accepted only in IDLE
- abort  in  1  synchronous; forces IDLE next cycle, no done
- pivot_valid  in  PCAM  per-entry valid
- pivot_row  in  PCAM*ROW_W  entry i at [i*ROW_W +: ROW_W]
- pivot_col  in  PCAM*COL_W  entry i at [i*COL_W +: COL_W]
- np_valid  in  NPCAM  per-entry valid
- np_row  in  NPCAM*ROW_W  same packing as pivot_row
- np_col  in  NPCAM*COL_W  same packing as pivot_col
- busy  out  1  high from the LOAD state through DONE
- done  out  1  one-cycle pulse when the result is final
- success  out  1  a legal candidate with zero uncovered non-pivot faults was found
- best_valid  out  1  at least one legal candidate was evaluated
- repair_sel  out  PCAM  bit i = 1: pivot i takes a spare row; 0: a spare column
- uncover_cnt  out  $clog2(NPCAM+1)  uncovered non-pivot faults for repair_sel

## Operation
- FSM states: IDLE, LOAD, SEARCH, DRAIN, DONE.
- IDLE + start: snapshot all CAM inputs into registers. Go to LOAD, clear result outputs, clear the eval register.
- LOAD: compute nv = popcount(pivot_valid).
  - nv > NUM_SR+NUM_SC: go to DONE (fast fail).
  - Otherwise: cand counter = 0, go to SEARCH.
- SEARCH: issue candidate sel = cand each cycle.
  - Register (legal, uncovered, sel) into the eval register.
  - Increment cand.
  - After issuing 2^PCAM-1, go to DRAIN.
- Legal candidate:
  - (sel & ~pivot_valid) == 0
  - popcount(sel & valid) ≤ NUM_SR
  - popcount(~sel & valid) ≤ NUM_SC
- Non-pivot j is covered when:
  - !np_valid[j], or
  - some valid pivot i has sel[i] and pivot_row[i]==np_row[j], or
  - some valid pivot i has !sel[i] and pivot_col[i]==np_col[j].
  - uncovered = count of non-covered entries.
- Compare stage (the cycle after issue, in SEARCH or DRAIN), when the eval register is legal:
  - If !best_valid or uncovered < uncover_cnt (strict): load repair_sel and uncover_cnt, set best_valid.
  - Ties keep the lowest candidate.
- Early hit: legal and uncovered==0 → success=1, go to DONE. A candidate issued in the same cycle is discarded.
- DRAIN: final compare, then go to DONE.
- DONE: done=1 for one cycle, then IDLE. Outputs hold until the next accepted start.
- No legal candidate: success=0, best_valid=0, repair_sel=0, uncover_cnt=NPCAM.
- start while not in IDLE: ignored.
- abort has priority over all transitions. Results are left as they stood.

## Timing
- Reset values: every output and state register is 0; FSM is in IDLE. uncover_cnt = 0 at reset.
- Cycle 0 = cycle in which start is sampled in IDLE.
- LOAD occupies cycle 1. Candidate k is issued in cycle 2+k and compared in cycle 3+k.
- Latencies:
  - Hit on candidate k: done in cycle 4+k.
  - Fast fail: done in cycle 2.
  - Exhaustive search: done in cycle 3+2^PCAM (259 at defaults).
- busy is high in cycles 1 through done inclusive. Next start is accepted in the cycle after done.
- Async rst_n mid-search: immediate IDLE, outputs 0, no done.
- abort: IDLE in the next cycle, busy low, done never asserted.

## Test plan
- Reset: hold rst_n low, drive random inputs → all outputs 0. Release, no start → no busy, no done.
- Pivot0 r5/c7 and pivot1 r9/c3 valid; np0 r5/c20 valid; start at cycle 0 → done in cycle 5, success=1, repair_sel=8'h01, uncover_cnt=0. Cycle 4 shows busy=1, done=0.
- Fast fail with NUM_SR=2, NUM_SC=2: five pivots valid → done in cycle 2, success=0, best_valid=0, repair_sel=0, uncover_cnt=30.
- Unrepairable: pivot0 r1/c1 only; np0 r1/c2, np1 r2/c1 → done in cycle 259, success=0, best_valid=1, repair_sel=8'h00, uncover_cnt=1.
- Abort and ignored start: scenario 4 with abort in cycle 50 → busy=0 in cycle 51, no done. Start pulses during busy are ignored. A fresh start reproduces the scenario-2 result.
- Async reset mid-search: drop rst_n in cycle 40 of scenario 4 → outputs 0 immediately, done never asserted. After release, scenario 2 completes normally.
